// File: rtl/nn_argmax_reader.sv
// Scans NUM_OUTPUTS signed activations from the network output buffer and
// reports the index and value of the largest one (lowest index wins ties).
module nn_argmax_reader #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_OUTPUTS = 10,
  parameter int ADDR_WIDTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  result_valid_o,
  input  logic                  result_ready_i,
  output logic [ADDR_WIDTH-1:0] class_o,
  output logic [DATA_WIDTH-1:0] max_value_o
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_OUTPUTS - 1);

  state_t                state;
  logic                  smp_vld;
  logic [ADDR_WIDTH-1:0] smp_idx;
  logic                  take;

  // Read data returns one cycle after the strobe, so the strobe and address
  // are delayed by one stage to tag the incoming datum.
  always_comb begin
    take = 1'b0;
    if (smp_vld)
      take = (smp_idx == '0) || ($signed(rd_data_i) > $signed(max_value_o));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= IDLE;
      busy_o         <= 1'b0;
      rd_en_o        <= 1'b0;
      rd_addr_o      <= '0;
      result_valid_o <= 1'b0;
      class_o        <= '0;
      max_value_o    <= '0;
      smp_vld        <= 1'b0;
      smp_idx        <= '0;
    end else begin
      smp_vld <= rd_en_o;
      smp_idx <= rd_addr_o;
      if (take) begin
        class_o     <= smp_idx;
        max_value_o <= rd_data_i;
      end
      case (state)
        IDLE: begin
          if (start_i) begin
            state     <= READ;
            busy_o    <= 1'b1;
            rd_en_o   <= 1'b1;
            rd_addr_o <= '0;
          end
        end
        READ: begin
          if (rd_addr_o == LAST_ADDR) begin
            state     <= DRAIN;
            rd_en_o   <= 1'b0;
            rd_addr_o <= '0;
          end else begin
            rd_addr_o <= rd_addr_o + 1'b1;
          end
        end
        DRAIN: begin
          state          <= DONE;
          result_valid_o <= 1'b1;
        end
        DONE: begin
          if (result_ready_i) begin
            state          <= IDLE;
            result_valid_o <= 1'b0;
            busy_o         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nn_argmax_reader.md
NN_ARGMAX_READER -- requirements
Module: nn_argmax_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: width of one signed output activation.
REQ-002 SHALL have parameter NUM_OUTPUTS, default 10: number of output neurons to scan (legal range 1 to 2^ADDR_WIDTH).
REQ-003 SHALL have parameter ADDR_WIDTH, default 4: width of the output-buffer read address.
REQ-004 SHALL use one clock, clk_i; reset is reset_i, synchronous and active-high.
REQ-005 clk_i  input  1  system clock, all state updates on rising edge.
REQ-006 reset_i  input  1  synchronous active-high reset.
REQ-007 start_i  input  1  request to scan the network output buffer.
REQ-008 busy_o  output  1  high whenever the block is not in IDLE.
REQ-009 rd_en_o  output  1  output-buffer read strobe.
REQ-010 rd_addr_o  output  ADDR_WIDTH  output-buffer read address.
REQ-011 rd_data_i  input  DATA_WIDTH  signed activation, valid exactly one cycle after its rd_en_o cycle.
REQ-012 result_valid_o  output  1  result available.
REQ-013 result_ready_i  input  1  consumer accepts result.
REQ-014 class_o  output  ADDR_WIDTH  index of the maximum activation.
REQ-015 max_value_o  output  DATA_WIDTH  signed value of the maximum activation.

Function
REQ-016 SHALL implement FSM states IDLE, READ, DRAIN, DONE.
REQ-017 IDLE: start_i high -> READ next cycle; start_i is ignored in every other state.
REQ-018 READ: rd_en_o high every cycle, rd_addr_o = 0, 1, ..., NUM_OUTPUTS-1 on consecutive cycles; after address NUM_OUTPUTS-1 is issued -> DRAIN.
REQ-019 DRAIN: rd_en_o low; captures the final rd_data_i -> DONE next cycle.
REQ-020 rd_addr_o SHALL be 0 whenever rd_en_o is low.
REQ-021 Timing: start_i high in IDLE at cycle t -> rd_en_o high cycles t+1..t+NUM_OUTPUTS; data sampled cycles t+2..t+NUM_OUTPUTS+1; result_valid_o first high at cycle t+NUM_OUTPUTS+2.
REQ-022 The first sampled datum (address 0) SHALL unconditionally load max with class 0.
REQ-023 Each later datum SHALL replace max/class only if signed rd_data_i > current max (strict); ties keep the lowest index.
REQ-024 Comparison SHALL be two's-complement signed over full DATA_WIDTH, with no saturation or truncation.
REQ-025 DONE: result_valid_o high; class_o and max_value_o held stable until handshake.
REQ-026 result_valid_o and result_ready_i both high on a rising edge -> IDLE next cycle, result_valid_o low; a start_i in that same cycle is ignored.
REQ-027 result_ready_i while not in DONE SHALL have no effect.
REQ-028 class_o and max_value_o SHALL keep their last result in IDLE until the next scan overwrites them at its first sample.
REQ-029 NUM_OUTPUTS = 1: single read of address 0, class_o = 0, max_value_o = that value, result_valid_o at t+3.
REQ-030 Back-to-back scans: consecutive start/handshake cycles SHALL each produce a fresh result, with no state carried between scans other than the REQ-028 hold.

Reset
REQ-031 reset_i high on a rising edge SHALL force IDLE, with busy_o, rd_en_o, rd_addr_o, result_valid_o, class_o and max_value_o all 0, regardless of state.
REQ-032 Reset asserted mid-scan SHALL abort the scan with no result_valid_o pulse; the next start_i after reset deasserts begins a full scan from address 0.

Verification
REQ-033 Values {3,-1,7,2,7,0,-5,1,4,6} (16-bit), start pulse at cycle t -> rd_addr_o 0..9 on cycles t+1..t+10, result_valid_o at t+12, class_o=2, max_value_o=7.
REQ-034 All ten values = -32768 -> class_o=0, max_value_o=-32768; then max at last index (value 5 at address 9) -> class_o=9, max_value_o=5.
REQ-035 result_ready_i held low 20 cycles in DONE -> result_valid_o, class_o and max_value_o stable; start_i pulses during scan and DONE are ignored; ready high -> IDLE next cycle, busy_o=0.
REQ-036 reset_i asserted one cycle during READ at address 4 -> next cycle all outputs 0, no valid; new start -> correct full scan result.
REQ-037 NUM_OUTPUTS=1 build, value -9 -> single read, result_valid_o at t+3, class_o=0, max_value_o=-9.
REQ-038 Two back-to-back scans with different data, ready tied high -> two single-cycle result_valid_o pulses, each with the correct class for its own data.
